// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared encodings for the clock-enable controller: FSM state
//               codes, mode codes, divide-exponent width and the exponent
//               clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] c_ST_HALT = 2'b00;
  localparam logic [1:0] c_ST_RUN  = 2'b01;
  localparam logic [1:0] c_ST_STEP = 2'b10;

  // Mode input codes; anything other than RUN behaves as HALT
  localparam logic [1:0] c_MODE_HALT = 2'b00;
  localparam logic [1:0] c_MODE_RUN  = 2'b01;

  // Width of a divide exponent (matches the div_sel port)
  localparam int c_EXP_W = 3;

  // Limit a requested exponent to the largest the counter can represent.
  function automatic logic [c_EXP_W-1:0] clamp_exp(
    input logic [c_EXP_W-1:0] sel,
    input int unsigned        max_exp
  );
    if (32'(sel) > max_exp) return c_EXP_W'(max_exp);
    return sel;
  endfunction

endpackage : clk_ctrl_pkg
`default_nettype wire

// File: rtl/clk_period_cnt.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_cnt
// Description : Period counter for the clock-enable controller. Counts
//               0..2^i_exp-1 while enabled, flags the last count and selects
//               the divided square-wave bit.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_en      - count enable (held at zero when low)
//               i_exp     - active divide exponent
//               o_wrap    - counter is at its last value (2^i_exp - 1)
//               o_clk_out - divided square wave (0 when i_exp == 0)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_cnt
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [c_EXP_W-1:0] i_exp,
  output logic               o_wrap,
  output logic               o_clk_out
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             w_clk_out;

  // Last count value is 2^i_exp - 1: the low i_exp bits set.
  always_comb begin
    w_last = '0;
    for (int i = 0; i < CNT_W; i++) begin
      w_last[i] = (int'(i_exp) > i);
    end
  end

  assign o_wrap = (r_cnt == w_last);

  // MSB of the active count range gives a 50% duty square wave.
  always_comb begin
    w_clk_out = 1'b0;
    if (i_exp != '0) begin
      w_clk_out = r_cnt[i_exp - c_EXP_W'(1)];
    end
  end

  assign o_clk_out = w_clk_out;

  // Disabled counter sits at zero so a restart always begins a full period.
  always_ff @(posedge clk) begin
    if (rst || !i_en || o_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : clk_period_cnt
`default_nettype wire

// File: rtl/clk_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_ctrl
// Description : Clock-enable controller. Generates a one-cycle CPU enable
//               once every 2^div_act cycles in RUN, or for a single period in
//               STEP, with glitch-free ratio changes at period boundaries.
// Ports       : clk_in      - clock, all logic on rising edge
//               rst         - synchronous active-high reset
//               mode        - 00 HALT, 01 RUN, 10/11 HALT
//               step_req    - request a single period (honoured in HALT)
//               div_sel     - requested divide exponent
//               div_load    - strobe capturing div_sel
//               cpu_ena     - one-cycle enable at the end of each period
//               clk_out     - divided square wave
//               running     - FSM in RUN or STEP
//               cfg_pending - a loaded ratio awaits its boundary
//               cfg_done    - pulse the cycle after a ratio is applied
//               step_done   - pulse the cycle after a STEP completes
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int MAX_LOG2 = 7,
  parameter int RST_LOG2 = 3
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         step_req,
  input  logic [2:0]   div_sel,
  input  logic         div_load,
  output logic         cpu_ena,
  output logic         clk_out,
  output logic         running,
  output logic         cfg_pending,
  output logic         cfg_done,
  output logic         step_done
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_EXP_W-1:0] r_div_act;
  logic [c_EXP_W-1:0] r_div_pend;
  logic               r_cfg_pending;
  logic               r_cfg_done;
  logic               r_step_done;

  logic               w_active;
  logic               w_wrap;
  logic               w_tick;
  logic               w_mode_run;
  logic               w_apply_pt;
  logic [c_EXP_W-1:0] w_sel_clamped;
  logic               w_cpu_ena;
  logic               w_running;

  assign w_mode_run    = (mode == c_MODE_RUN);
  assign w_active      = (r_state == c_ST_RUN) || (r_state == c_ST_STEP);
  assign w_tick        = w_active && w_wrap;
  assign w_sel_clamped = clamp_exp(div_sel, MAX_LOG2);

  // A ratio may only change where no period is in flight: at a tick, or
  // anywhere while halted.
  assign w_apply_pt = (r_state == c_ST_HALT) || w_tick;

  clk_period_cnt #(
    .CNT_W (MAX_LOG2)
  ) u_cnt (
    .clk       (clk_in),
    .rst       (rst),
    .i_en      (w_active),
    .i_exp     (r_div_act),
    .o_wrap    (w_wrap),
    .o_clk_out (clk_out)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= c_ST_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_HALT: begin
        if (w_mode_run) begin
          w_state_nxt = c_ST_RUN;
        end else if (step_req) begin
          w_state_nxt = c_ST_STEP;
        end
      end
      c_ST_RUN: begin
        // Only leave at a period boundary so no partial period is emitted.
        if (w_tick && !w_mode_run) begin
          w_state_nxt = c_ST_HALT;
        end
      end
      c_ST_STEP: begin
        if (w_tick) begin
          w_state_nxt = c_ST_HALT;
        end
      end
      default: w_state_nxt = c_ST_HALT;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // cpu_ena is masked by rst so a reset landing on a tick cycle never fires.
  always_comb begin
    w_running = (r_state != c_ST_HALT);
    w_cpu_ena = w_tick && !rst;
  end

  assign running     = w_running;
  assign cpu_ena     = w_cpu_ena;
  assign cfg_pending = r_cfg_pending;
  assign cfg_done    = r_cfg_done;
  assign step_done   = r_step_done;

  // ----------------------------------------------------------- ratio handling
  // A load coinciding with an apply point bypasses the pending register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_div_act     <= c_EXP_W'(RST_LOG2);
      r_div_pend    <= c_EXP_W'(RST_LOG2);
      r_cfg_pending <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_step_done   <= 1'b0;
    end else begin
      r_cfg_done  <= 1'b0;
      r_step_done <= (r_state == c_ST_STEP) && w_tick;
      if (w_apply_pt && div_load) begin
        r_div_act     <= w_sel_clamped;
        r_div_pend    <= w_sel_clamped;
        r_cfg_pending <= 1'b0;
        r_cfg_done    <= 1'b1;
      end else if (w_apply_pt && r_cfg_pending) begin
        r_div_act     <= r_div_pend;
        r_cfg_pending <= 1'b0;
        r_cfg_done    <= 1'b1;
      end else if (div_load) begin
        r_div_pend    <= w_sel_clamped;
        r_cfg_pending <= 1'b1;
      end
    end
  end

endmodule : clk_en_ctrl
`default_nettype wire

// File: tb/tb_clk_en_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_en_ctrl
// Description : Directed self-checking bench for clk_en_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_en_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       step_req = 1'b0;
  logic [2:0] div_sel = 3'd0;
  logic       div_load = 1'b0;
  logic       cpu_ena;
  logic       clk_out;
  logic       running;
  logic       cfg_pending;
  logic       cfg_done;
  logic       step_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  clk_en_ctrl #(
    .MAX_LOG2 (7),
    .RST_LOG2 (3)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .mode        (mode),
    .step_req    (step_req),
    .div_sel     (div_sel),
    .div_load    (div_load),
    .cpu_ena     (cpu_ena),
    .clk_out     (clk_out),
    .running     (running),
    .cfg_pending (cfg_pending),
    .cfg_done    (cfg_done),
    .step_done   (step_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 2'b00; step_req = 1'b0; div_sel = 3'd0; div_load = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b01; step_req = 1'b1; div_sel = 3'd5; div_load = 1'b1;
    cycle(); cycle();
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL reset cpu_ena got=%b exp=0", cpu_ena); end
    vec_cnt++; if (clk_out !== 1'b0) begin err_cnt++; $display("FAIL reset clk_out got=%b exp=0", clk_out); end
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL reset running got=%b exp=0", running); end
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL reset cfg_pending got=%b exp=0", cfg_pending); end
    vec_cnt++; if (cfg_done !== 1'b0) begin err_cnt++; $display("FAIL reset cfg_done got=%b exp=0", cfg_done); end
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL reset step_done got=%b exp=0", step_done); end
    do_reset();
    cycle();
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL post_reset running got=%b exp=0", running); end
  endtask

  task automatic test_run_div8();
    int c;
    do_reset();
    mode = 2'b01;
    for (int k = 0; k < 24; k++) begin
      cycle();
      c = k % 8;
      vec_cnt++; if (cpu_ena !== (c == 7)) begin err_cnt++; $display("FAIL run8 cpu_ena k=%0d got=%b exp=%b", k, cpu_ena, (c == 7)); end
      vec_cnt++; if (clk_out !== (c >= 4)) begin err_cnt++; $display("FAIL run8 clk_out k=%0d got=%b exp=%b", k, clk_out, (c >= 4)); end
      vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL run8 running k=%0d got=%b exp=1", k, running); end
    end
  endtask

  task automatic test_halt_mid();
    do_reset();
    mode = 2'b01;
    cycle();
    repeat (3) cycle();
    mode = 2'b00;
    for (int k = 4; k < 8; k++) begin
      cycle();
      vec_cnt++; if (cpu_ena !== (k == 7)) begin err_cnt++; $display("FAIL halt_mid cpu_ena cnt=%0d got=%b exp=%b", k, cpu_ena, (k == 7)); end
      vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL halt_mid running cnt=%0d got=%b exp=1", k, running); end
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL halted cpu_ena k=%0d got=%b exp=0", k, cpu_ena); end
      vec_cnt++; if (clk_out !== 1'b0) begin err_cnt++; $display("FAIL halted clk_out k=%0d got=%b exp=0", k, clk_out); end
      vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL halted running k=%0d got=%b exp=0", k, running); end
    end
    // Mode 10 must behave as HALT
    mode = 2'b10;
    repeat (3) cycle();
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL mode10 running got=%b exp=0", running); end
  endtask

  task automatic test_step();
    do_reset();
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL step running got=%b exp=1", running); end
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL step cpu_ena0 got=%b exp=0", cpu_ena); end
    for (int k = 1; k < 8; k++) begin
      step_req = (k == 3);
      cycle();
      vec_cnt++; if (cpu_ena !== (k == 7)) begin err_cnt++; $display("FAIL step cpu_ena cnt=%0d got=%b exp=%b", k, cpu_ena, (k == 7)); end
      vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL step step_done cnt=%0d got=%b exp=0", k, step_done); end
    end
    step_req = 1'b0;
    cycle();
    vec_cnt++; if (step_done !== 1'b1) begin err_cnt++; $display("FAIL step_done pulse got=%b exp=1", step_done); end
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL step end running got=%b exp=0", running); end
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL step end cpu_ena got=%b exp=0", cpu_ena); end
    cycle();
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL step_done width got=%b exp=0", step_done); end
  endtask

  task automatic test_priority();
    do_reset();
    mode = 2'b01; step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    repeat (7) cycle();
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL prio cpu_ena got=%b exp=1", cpu_ena); end
    cycle();
    vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL prio running got=%b exp=1", running); end
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL prio step_done got=%b exp=0", step_done); end
  endtask

  task automatic test_ratio_change();
    do_reset();
    mode = 2'b01;
    cycle(); cycle(); cycle();
    div_sel = 3'd1; div_load = 1'b1;
    cycle();
    div_load = 1'b0;
    vec_cnt++; if (cfg_pending !== 1'b1) begin err_cnt++; $display("FAIL ratio pending got=%b exp=1", cfg_pending); end
    vec_cnt++; if (cfg_done !== 1'b0) begin err_cnt++; $display("FAIL ratio early done got=%b exp=0", cfg_done); end
    for (int k = 4; k < 8; k++) begin
      cycle();
      vec_cnt++; if (cfg_pending !== 1'b1) begin err_cnt++; $display("FAIL ratio pending cnt=%0d got=%b exp=1", k, cfg_pending); end
      vec_cnt++; if (cpu_ena !== (k == 7)) begin err_cnt++; $display("FAIL ratio cpu_ena cnt=%0d got=%b exp=%b", k, cpu_ena, (k == 7)); end
    end
    cycle();
    vec_cnt++; if (cfg_done !== 1'b1) begin err_cnt++; $display("FAIL ratio cfg_done got=%b exp=1", cfg_done); end
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL ratio cleared got=%b exp=0", cfg_pending); end
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL ratio new cnt0 cpu_ena got=%b exp=0", cpu_ena); end
    for (int j = 1; j < 7; j++) begin
      cycle();
      vec_cnt++; if (cpu_ena !== (j % 2 == 1)) begin err_cnt++; $display("FAIL div2 cpu_ena j=%0d got=%b exp=%b", j, cpu_ena, (j % 2 == 1)); end
      vec_cnt++; if (clk_out !== (j % 2 == 1)) begin err_cnt++; $display("FAIL div2 clk_out j=%0d got=%b exp=%b", j, clk_out, (j % 2 == 1)); end
      vec_cnt++; if (cfg_done !== 1'b0) begin err_cnt++; $display("FAIL div2 cfg_done j=%0d got=%b exp=0", j, cfg_done); end
    end
  endtask

  task automatic test_overwrite();
    do_reset();
    mode = 2'b01;
    cycle();
    div_sel = 3'd5; div_load = 1'b1;
    cycle();
    div_sel = 3'd2;
    cycle();
    div_load = 1'b0;
    repeat (5) cycle();
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL ovw tick got=%b exp=1", cpu_ena); end
    vec_cnt++; if (cfg_pending !== 1'b1) begin err_cnt++; $display("FAIL ovw pending got=%b exp=1", cfg_pending); end
    cycle();
    vec_cnt++; if (cfg_done !== 1'b1) begin err_cnt++; $display("FAIL ovw cfg_done got=%b exp=1", cfg_done); end
    repeat (3) cycle();
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL ovw div4 cpu_ena got=%b exp=1", cpu_ena); end
    vec_cnt++; if (clk_out !== 1'b1) begin err_cnt++; $display("FAIL ovw div4 clk_out got=%b exp=1", clk_out); end
  endtask

  task automatic test_bypass();
    do_reset();
    mode = 2'b01;
    cycle();
    repeat (7) cycle();
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL byp tick got=%b exp=1", cpu_ena); end
    div_sel = 3'd2; div_load = 1'b1;
    cycle();
    div_load = 1'b0;
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL byp pending got=%b exp=0", cfg_pending); end
    vec_cnt++; if (cfg_done !== 1'b1) begin err_cnt++; $display("FAIL byp cfg_done got=%b exp=1", cfg_done); end
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL byp cnt0 cpu_ena got=%b exp=0", cpu_ena); end
    for (int k = 1; k < 4; k++) begin
      cycle();
      vec_cnt++; if (cpu_ena !== (k == 3)) begin err_cnt++; $display("FAIL byp cpu_ena cnt=%0d got=%b exp=%b", k, cpu_ena, (k == 3)); end
      vec_cnt++; if (clk_out !== (k >= 2)) begin err_cnt++; $display("FAIL byp clk_out cnt=%0d got=%b exp=%b", k, clk_out, (k >= 2)); end
    end
  endtask

  task automatic test_halt_load_run();
    do_reset();
    div_sel = 3'd0; div_load = 1'b1; mode = 2'b01;
    cycle();
    div_load = 1'b0;
    vec_cnt++; if (running !== 1'b1) begin err_cnt++; $display("FAIL hlr running got=%b exp=1", running); end
    vec_cnt++; if (cfg_done !== 1'b1) begin err_cnt++; $display("FAIL hlr cfg_done got=%b exp=1", cfg_done); end
    vec_cnt++; if (cfg_pending !== 1'b0) begin err_cnt++; $display("FAIL hlr pending got=%b exp=0", cfg_pending); end
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL hlr cpu_ena got=%b exp=1", cpu_ena); end
    for (int k = 0; k < 5; k++) begin
      cycle();
      vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL div1 cpu_ena k=%0d got=%b exp=1", k, cpu_ena); end
      vec_cnt++; if (clk_out !== 1'b0) begin err_cnt++; $display("FAIL div1 clk_out k=%0d got=%b exp=0", k, clk_out); end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    mode = 2'b01;
    cycle();
    repeat (5) cycle();
    rst = 1'b1;
    cycle();
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL abort cpu_ena got=%b exp=0", cpu_ena); end
    vec_cnt++; if (clk_out !== 1'b0) begin err_cnt++; $display("FAIL abort clk_out got=%b exp=0", clk_out); end
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL abort running got=%b exp=0", running); end
    vec_cnt++; if (cfg_done !== 1'b0) begin err_cnt++; $display("FAIL abort cfg_done got=%b exp=0", cfg_done); end
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL abort step_done got=%b exp=0", step_done); end
    // Reset landing on the final cycle of a STEP
    do_reset();
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    repeat (7) cycle();
    vec_cnt++; if (cpu_ena !== 1'b1) begin err_cnt++; $display("FAIL abort_step tick got=%b exp=1", cpu_ena); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (cpu_ena !== 1'b0) begin err_cnt++; $display("FAIL abort_step masked cpu_ena got=%b exp=0", cpu_ena); end
    cycle();
    rst = 1'b0;
    vec_cnt++; if (running !== 1'b0) begin err_cnt++; $display("FAIL abort_step running got=%b exp=0", running); end
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL abort_step step_done got=%b exp=0", step_done); end
    cycle();
    vec_cnt++; if (step_done !== 1'b0) begin err_cnt++; $display("FAIL abort_step late step_done got=%b exp=0", step_done); end
  endtask

  initial begin
    test_reset();
    test_run_div8();
    test_halt_mid();
    test_step();
    test_priority();
    test_ratio_change();
    test_overwrite();
    test_bypass();
    test_halt_load_run();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

endmodule : tb_clk_en_ctrl
`default_nettype wire
